// File: rtl/ddr2_port_sched_pkg.sv
// Shared widths, requester indices and scheduler state encoding for the
// DDR port 2 read-channel scheduler.
package GLOBAL_PARAM;

    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 16;

    localparam int REQ_NUM  = 3;
    localparam int REQ_IBUF = 0;
    localparam int REQ_PBUF = 1;
    localparam int REQ_ABUF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } ddr_sched_state_t;

    // Index width for a requester count; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr2_port_sched_rr_pick.sv
// Combinational round-robin picker: the first set request at or after
// rr_ptr (wrapping) wins.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] win
);

    // Scan from the farthest candidate back to rr_ptr so the nearest set
    // request is the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % N]) begin
                valid = 1'b1;
                win   = IW'((int'(rr_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/ddr2_port_sched.sv
// Round-robin scheduler for the DDR port 2 read channel shared by the
// ibuf, pbuf and abuf loaders.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | port free; arbitrate and latch winner parameters
// ST_ISSUE   | one cycle: start address generator and winning loader
// ST_BUSY    | transfer running; collect ag_done / ld_done[win]
// ST_RELEASE | one cycle: pulse xfer_done[win], advance rr_ptr
module ddr2_port_sched #(
    parameter int REQ_NUM    = GLOBAL_PARAM::REQ_NUM,
    parameter int DDR_ADDR_W = GLOBAL_PARAM::DDR_ADDR_W,
    parameter int BURST_W    = GLOBAL_PARAM::BURST_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQ_NUM-1:0]                  req,
    input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]  req_st_addr,
    input  logic [REQ_NUM-1:0][BURST_W-1:0]     req_burst,
    input  logic [REQ_NUM-1:0][DDR_ADDR_W-1:0]  req_step,
    input  logic [REQ_NUM-1:0][BURST_W-1:0]     req_burst_num,
    output logic [REQ_NUM-1:0]                  gnt,
    output logic [REQ_NUM-1:0]                  ld_start,
    input  logic [REQ_NUM-1:0]                  ld_done,
    input  logic [REQ_NUM-1:0]                  ld_ready,
    output logic                                ddr2_ready,
    output logic                                ag_start,
    output logic [DDR_ADDR_W-1:0]               ag_st_addr,
    output logic [BURST_W-1:0]                  ag_burst,
    output logic [DDR_ADDR_W-1:0]               ag_step,
    output logic [BURST_W-1:0]                  ag_burst_num,
    input  logic                                ag_done,
    output logic [REQ_NUM-1:0]                  xfer_done,
    output logic                                busy
);

    localparam int IW = GLOBAL_PARAM::idx_w(REQ_NUM);

    GLOBAL_PARAM::ddr_sched_state_t state, state_nxt;

    logic [IW-1:0]      win_q;
    logic [IW-1:0]      rr_ptr;
    logic               pick_valid;
    logic [IW-1:0]      pick_win;
    logic               ag_fin;
    logic               ld_fin;
    logic               ag_all;
    logic               ld_all;
    logic [REQ_NUM-1:0] win_oh;

    rr_pick #(
        .N  (REQ_NUM),
        .IW (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .win    (pick_win)
    );

    // Winner decode plus done-collection including same-cycle pulses, so the
    // later done pulse moves BUSY to RELEASE on its own edge.
    always_comb begin
        win_oh = '0;
        win_oh[win_q] = 1'b1;
        ag_all = ag_fin | ag_done;
        ld_all = ld_fin | ld_done[win_q];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GLOBAL_PARAM::ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            GLOBAL_PARAM::ST_IDLE:    if (pick_valid) state_nxt = GLOBAL_PARAM::ST_ISSUE;
            GLOBAL_PARAM::ST_ISSUE:   state_nxt = GLOBAL_PARAM::ST_BUSY;
            GLOBAL_PARAM::ST_BUSY:    if (ag_all && ld_all) state_nxt = GLOBAL_PARAM::ST_RELEASE;
            GLOBAL_PARAM::ST_RELEASE: state_nxt = GLOBAL_PARAM::ST_IDLE;
            default:                  state_nxt = GLOBAL_PARAM::ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered winner.
    always_comb begin
        gnt        = '0;
        ld_start   = '0;
        xfer_done  = '0;
        ag_start   = 1'b0;
        ddr2_ready = 1'b0;
        busy       = (state != GLOBAL_PARAM::ST_IDLE);
        case (state)
            GLOBAL_PARAM::ST_ISSUE: begin
                gnt        = win_oh;
                ld_start   = win_oh;
                ag_start   = 1'b1;
                ddr2_ready = ld_ready[win_q];
            end
            GLOBAL_PARAM::ST_BUSY: begin
                gnt        = win_oh;
                ddr2_ready = ld_ready[win_q];
            end
            GLOBAL_PARAM::ST_RELEASE: begin
                gnt       = win_oh;
                xfer_done = win_oh;
            end
            default: ;
        endcase
    end

    // Winner/parameter latch, sticky done flags and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q        <= '0;
            rr_ptr       <= '0;
            ag_fin       <= 1'b0;
            ld_fin       <= 1'b0;
            ag_st_addr   <= '0;
            ag_burst     <= '0;
            ag_step      <= '0;
            ag_burst_num <= '0;
        end else begin
            case (state)
                GLOBAL_PARAM::ST_IDLE: begin
                    if (pick_valid) begin
                        win_q        <= pick_win;
                        ag_st_addr   <= req_st_addr[pick_win];
                        ag_burst     <= req_burst[pick_win];
                        ag_step      <= req_step[pick_win];
                        ag_burst_num <= req_burst_num[pick_win];
                    end
                end
                GLOBAL_PARAM::ST_BUSY: begin
                    ag_fin <= ag_all;
                    ld_fin <= ld_all;
                end
                GLOBAL_PARAM::ST_RELEASE: begin
                    ag_fin <= 1'b0;
                    ld_fin <= 1'b0;
                    rr_ptr <= (win_q == IW'(REQ_NUM - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
